// File: rtl/dmem_io_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_io_responder
// Description : Data-port responder for a single-cycle MIPS datapath. Decodes
//               the byte address into a word-addressed data RAM and a small
//               memory-mapped I/O block (LED, switches, cycle counter).
//               Stalls the processor for one cycle while a RAM read is in
//               flight.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_io_responder #(
    parameter int               DBITS     = 32,
    parameter int               NLOC      = 64,
    parameter logic [DBITS-1:0] DMEM_BASE = 32'h1001_0000,
    parameter logic [DBITS-1:0] IO_BASE   = 32'h1003_0000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DBITS-1:0] mem_addr,
    input  logic [DBITS-1:0] mem_writedata,
    input  logic             mem_wr,
    input  logic             mem_rd,
    output logic [DBITS-1:0] mem_readdata,
    output logic             enable,
    input  logic [15:0]      sw,
    output logic [15:0]      led,
    output logic             addr_err
);

    localparam int               c_AW       = $clog2(NLOC);
    localparam logic [DBITS-1:0] c_DMEM_END = DMEM_BASE + DBITS'(4 * NLOC);
    localparam logic [DBITS-1:0] c_IO_LED   = IO_BASE;
    localparam logic [DBITS-1:0] c_IO_SW    = IO_BASE + DBITS'(4);
    localparam logic [DBITS-1:0] c_IO_CYC   = IO_BASE + DBITS'(8);
    localparam logic [DBITS-1:0] c_ONE      = DBITS'(1);

    localparam logic [0:0] c_ST_IDLE    = 1'b0;
    localparam logic [0:0] c_ST_RD_WAIT = 1'b1;

    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic [15:0]      r_led;
    logic [DBITS-1:0] r_cycles;
    logic             r_addr_err;
    logic [DBITS-1:0] r_ram [NLOC];
    logic [DBITS-1:0] r_ram_q;

    logic             w_dmem_hit;
    logic             w_io_led;
    logic             w_io_sw;
    logic             w_io_cyc;
    logic             w_unmapped;
    logic             w_rd_only;
    logic             w_ram_we;
    logic             w_ram_re;
    logic [c_AW-1:0]  w_idx;
    logic             w_enable;
    logic [DBITS-1:0] w_rdata;

    // Low two address bits take part only in the RAM range check; I/O
    // registers are matched on the word address.
    assign w_dmem_hit = (mem_addr >= DMEM_BASE) && (mem_addr < c_DMEM_END);
    assign w_io_led   = (mem_addr[DBITS-1:2] == c_IO_LED[DBITS-1:2]);
    assign w_io_sw    = (mem_addr[DBITS-1:2] == c_IO_SW[DBITS-1:2]);
    assign w_io_cyc   = (mem_addr[DBITS-1:2] == c_IO_CYC[DBITS-1:2]);
    assign w_unmapped = !(w_dmem_hit || w_io_led || w_io_sw || w_io_cyc);
    assign w_idx      = mem_addr[c_AW+1:2];

    // A simultaneous read and write is handled purely as a write.
    assign w_rd_only  = mem_rd && !mem_wr;
    assign w_ram_we   = mem_wr && w_dmem_hit;
    assign w_ram_re   = (r_state == c_ST_IDLE) && w_rd_only && w_dmem_hit;

    // Data RAM: synchronous write, registered read launched from IDLE only.
    always_ff @(posedge clk) begin
        if (w_ram_we) begin
            r_ram[w_idx] <= mem_writedata;
        end
        if (w_ram_re) begin
            r_ram_q <= r_ram[w_idx];
        end
    end

    // Control state, I/O registers, free-running counter and sticky error.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= c_ST_IDLE;
            r_led      <= 16'h0000;
            r_cycles   <= '0;
            r_addr_err <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (mem_wr && w_io_led) begin
                r_led <= mem_writedata[15:0];
            end
            // Clearing write takes priority over the per-cycle increment.
            if (mem_wr && w_io_cyc) begin
                r_cycles <= '0;
            end else begin
                r_cycles <= r_cycles + c_ONE;
            end
            if ((mem_rd || mem_wr) && w_unmapped) begin
                r_addr_err <= 1'b1;
            end
        end
    end

    // Next state, stall and read-data mux; reset forces enable high and data low.
    always_comb begin
        w_state_nxt = r_state;
        w_enable    = 1'b1;
        w_rdata     = '0;
        if (r_state == c_ST_RD_WAIT) begin
            w_rdata     = r_ram_q;
            w_state_nxt = c_ST_IDLE;
        end else if (w_ram_re) begin
            w_enable    = 1'b0;
            w_state_nxt = c_ST_RD_WAIT;
        end else if (w_rd_only) begin
            if (w_io_led) begin
                w_rdata = {{(DBITS-16){1'b0}}, r_led};
            end else if (w_io_sw) begin
                w_rdata = {{(DBITS-16){1'b0}}, sw};
            end else if (w_io_cyc) begin
                w_rdata = r_cycles;
            end
        end
        if (!reset) begin
            w_enable = 1'b1;
            w_rdata  = '0;
        end
    end

    assign mem_readdata = w_rdata;
    assign enable       = w_enable;
    assign led          = r_led;
    assign addr_err     = r_addr_err;

endmodule
`default_nettype wire

// File: tb/tb_dmem_io_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_io_responder
// Description : Scenario bench for dmem_io_responder. Load expectations are
//               queued when a request is issued and retired when the
//               responder raises enable with data.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_io_responder;

    localparam logic [31:0] c_DMEM = 32'h1001_0000;
    localparam logic [31:0] c_IO   = 32'h1003_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_writedata = '0;
    logic        mem_wr = 1'b0;
    logic        mem_rd = 1'b0;
    logic [31:0] mem_readdata;
    logic        enable;
    logic [15:0] sw = '0;
    logic [15:0] led;
    logic        addr_err;

    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_q[$];

    dmem_io_responder #(
        .DBITS(32), .NLOC(64), .DMEM_BASE(32'h1001_0000), .IO_BASE(32'h1003_0000)
    ) dut (
        .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_writedata(mem_writedata),
        .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_readdata(mem_readdata),
        .enable(enable), .sw(sw), .led(led), .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    // Tasks start and end at posedge+1 with the bus idle.
    task automatic do_read(input logic [31:0] a, input logic [31:0] exp, input int exp_stall,
                           input string name);
        int          stalls;
        bit          got;
        logic [31:0] e;
        exp_q.push_back(exp);
        mem_addr = a;
        mem_rd   = 1'b1;
        stalls   = 0;
        got      = 1'b0;
        for (int i = 0; i < 4 && !got; i++) begin
            @(negedge clk);
            if (enable === 1'b1) got = 1'b1;
            else begin
                stalls++;
                @(posedge clk);
            end
        end
        total++;
        if (!got) begin
            bad++;
            $display("FAIL %s timeout: enable never returned to 1", name);
            void'(exp_q.pop_front());
        end else begin
            e = exp_q.pop_front();
            if (mem_readdata !== e) begin
                bad++;
                $display("FAIL %s data: got %h expected %h", name, mem_readdata, e);
            end
            total++;
            if (stalls != exp_stall) begin
                bad++;
                $display("FAIL %s stalls: got %0d expected %0d", name, stalls, exp_stall);
            end
        end
        @(posedge clk);
        #1;
        mem_rd = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic rd,
                            input string name);
        mem_addr      = a;
        mem_writedata = d;
        mem_wr        = 1'b1;
        mem_rd        = rd;
        @(negedge clk);
        total++;
        if (enable !== 1'b1) begin
            bad++;
            $display("FAIL %s enable: got %b expected 1", name, enable);
        end
        total++;
        if (mem_readdata !== 32'h0) begin
            bad++;
            $display("FAIL %s readdata: got %h expected 0", name, mem_readdata);
        end
        @(posedge clk);
        #1;
        mem_wr = 1'b0;
        mem_rd = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        mem_addr = c_DMEM + 32'h8;
        mem_rd   = 1'b1;
        @(negedge clk);
        total++;
        if (enable !== 1'b1 || mem_readdata !== 32'h0 || led !== 16'h0 || addr_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: en=%b rd=%h led=%h err=%b expected 1/0/0/0",
                     enable, mem_readdata, led, addr_err);
        end
        mem_rd = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_cycles();
        repeat (10) @(posedge clk);
        #1;
        do_read(c_IO + 32'h8, 32'd10, 0, "cycles_10");
        do_write(c_IO + 32'h8, 32'h1234_5678, 1'b0, "cycles_clr_wr");
        do_read(c_IO + 32'h8, 32'd0, 0, "cycles_cleared");
        force dut.r_cycles = 32'hFFFF_FFFF;
        do_read(c_IO + 32'h8, 32'hFFFF_FFFF, 0, "cycles_max");
        release dut.r_cycles;
        @(posedge clk);
        #1;
        do_read(c_IO + 32'h8, 32'd0, 0, "cycles_wrap");
    endtask

    task automatic test_ram();
        do_write(c_DMEM + 32'h8, 32'hDEAD_BEEF, 1'b0, "ram_store");
        do_read(c_DMEM + 32'h8, 32'hDEAD_BEEF, 1, "ram_load");
        do_write(c_DMEM, 32'h0BAD_F00D, 1'b0, "ram_store0");
        do_write(c_DMEM + 32'hFC, 32'hCAFE_0001, 1'b0, "ram_store_last");
        do_read(c_DMEM + 32'hFC, 32'hCAFE_0001, 1, "ram_load_last");
        do_read(c_DMEM + 32'h8, 32'hDEAD_BEEF, 1, "ram_load_again");
    endtask

    task automatic test_io();
        do_write(c_IO, 32'h0001_A5A5, 1'b0, "led_wr");
        @(negedge clk);
        total++;
        if (led !== 16'hA5A5) begin
            bad++;
            $display("FAIL led_value: got %h expected a5a5", led);
        end
        @(posedge clk);
        #1;
        do_read(c_IO, 32'h0000_A5A5, 0, "led_rd");
        sw = 16'h1234;
        do_read(c_IO + 32'h4, 32'h0000_1234, 0, "sw_rd");
        do_write(c_IO + 32'h4, 32'hFFFF_FFFF, 1'b0, "sw_wr_ignored");
        do_read(c_IO, 32'h0000_A5A5, 0, "led_after_sw_wr");
    endtask

    task automatic test_unmapped();
        total++;
        if (addr_err !== 1'b0) begin
            bad++;
            $display("FAIL err_clear_before: got %b expected 0", addr_err);
        end
        do_write(c_DMEM + 32'h100, 32'h7777_7777, 1'b0, "unm_ram_wr");
        do_read(c_DMEM + 32'h100, 32'h0, 0, "unm_ram_rd");
        do_write(c_IO + 32'hC, 32'h0000_5A5A, 1'b0, "unm_io_wr");
        do_read(c_IO + 32'hC, 32'h0, 0, "unm_io_rd");
        @(negedge clk);
        total++;
        if (addr_err !== 1'b1 || led !== 16'hA5A5) begin
            bad++;
            $display("FAIL unm_side_effects: err=%b led=%h expected 1/a5a5", addr_err, led);
        end
        @(posedge clk);
        #1;
        do_read(c_DMEM, 32'h0BAD_F00D, 1, "unm_ram_intact");
    endtask

    task automatic test_rd_wr_both();
        do_write(c_DMEM + 32'h4, 32'h5, 1'b1, "rdwr_both");
        do_read(c_DMEM + 32'h4, 32'h5, 1, "rdwr_followup");
    endtask

    task automatic test_reset_in_wait();
        mem_addr = c_DMEM + 32'h8;
        mem_rd   = 1'b1;
        @(negedge clk);
        total++;
        if (enable !== 1'b0) begin
            bad++;
            $display("FAIL rst_wait_stall: got %b expected 0", enable);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        total++;
        if (enable !== 1'b1 || led !== 16'h0 || addr_err !== 1'b0 || mem_readdata !== 32'h0) begin
            bad++;
            $display("FAIL rst_wait_state: en=%b led=%h err=%b rd=%h expected 1/0/0/0",
                     enable, led, addr_err, mem_readdata);
        end
        mem_rd = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        do_read(c_DMEM + 32'h8, 32'hDEAD_BEEF, 1, "rst_wait_reload");
    endtask

    task automatic test_back_to_back();
        do_read(c_DMEM + 32'h4, 32'h5, 1, "b2b_ram0");
        do_read(c_DMEM + 32'hFC, 32'hCAFE_0001, 1, "b2b_ram1");
        do_read(c_IO + 32'h4, 32'h0000_1234, 0, "b2b_sw");
    endtask

    initial begin
        test_reset();
        test_cycles();
        test_ram();
        test_io();
        test_unmapped();
        test_rd_wr_both();
        test_reset_in_wait();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dmem_io_responder.md
Name: dmem_io_responder

Overview:
- Memory-side responder for the single-cycle MIPS datapath's data port. Decodes mem_addr and services loads and stores into a word-addressed data RAM and a small set of memory-mapped I/O registers.
- Stalls the processor through enable while a RAM read is in flight.
- Sits between datapath/controller and board I/O; drives datapath mem_readdata and the programcounter enable.

Parameters:
- Dbits, 32, data/address width in bits.
- Nloc, 64, number of data RAM words (power of two).
- DMEM_BASE, 32'h1001_0000, byte base address of data RAM.
- IO_BASE, 32'h1003_0000, byte base address of I/O register block.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-low; clears all state immediately when 0.
- mem_addr  input  Dbits  byte address from ALU result.
- mem_writedata  input  Dbits  store data (rt register).
- mem_wr  input  1  store request, this cycle.
- mem_rd  input  1  load request, this cycle.
- mem_readdata  output  Dbits  load data to register-file write mux.
- enable  output  1  processor advance; 0 freezes PC and register writes.
- sw  input  16  board switches.
- led  output  16  board LEDs.
- addr_err  output  1  sticky unmapped-access flag.

Behaviour:
- Address decode: mem_addr[1:0] ignored (word accesses only).
- dmem_hit when DMEM_BASE <= mem_addr < DMEM_BASE + 4*Nloc; RAM index is mem_addr[$clog2(Nloc)+1:2].
- I/O offsets from IO_BASE: +0 LED (RW, low 16 bits), +4 SW (RO, zero-extended), +8 CYCLES (RO, write clears). Any other address is unmapped.
- Data RAM: synchronous read, 1-cycle latency; synchronous write. Contents undefined after reset; not cleared.
- FSM states IDLE and RD_WAIT; reset state IDLE.
  - IDLE, mem_rd & !mem_wr & dmem_hit: launch RAM read, enable=0 (combinational), next state RD_WAIT.
  - RD_WAIT: mem_readdata = registered RAM output, enable=1, next state IDLE unconditionally. Datapath holds the same instruction and address across both cycles, so the load completes in 2 cycles.
  - All other cases in IDLE: enable=1, stay IDLE.
- I/O reads: zero wait. mem_readdata is combinational from the register or sw the same cycle; enable=1.
- Unmapped read: mem_readdata=0, enable=1, addr_err set.
- Writes: single cycle, never stall. On mem_wr & dmem_hit, the RAM word is written at the clock edge.
  - Write to LED loads mem_writedata[15:0].
  - Write to CYCLES zeroes the counter; the clear wins over the increment.
  - Write to SW is ignored.
  - Unmapped write is ignored and sets addr_err.
- mem_rd & mem_wr together: treated as a write; no stall; mem_readdata=0.
- No request: mem_readdata=0.
- CYCLES: Dbits counter, +1 every clock; wraps from all-ones to 0. It does not pause during stalls.
- addr_err: set by any unmapped access; cleared only by reset.
- Reset values (while reset=0): state IDLE, enable=1 (forced, regardless of mem_rd), mem_readdata=0, led=0, CYCLES=0, addr_err=0.
- Reset asserted in RD_WAIT: read abandoned, IDLE on release. The next mem_rd restarts the full 2-cycle sequence.

Test Plan:
- Store 32'hDEAD_BEEF to 32'h1001_0008, then load the same address. Store: enable stays 1. Load: cycle 1 enable=0; cycle 2 enable=1 and mem_readdata=32'hDEAD_BEEF; FSM back in IDLE.
- Write 32'h0001_A5A5 to 32'h1003_0000 -> led=16'hA5A5 next cycle. Set sw=16'h1234 and read 32'h1003_0004 -> mem_readdata=32'h0000_1234 same cycle, enable=1.
- Run 10 cycles after reset release, then read 32'h1003_0008 -> 10. Write any value to 32'h1003_0008 -> counter reads 0 the following cycle. Force counter to 32'hFFFF_FFFF -> next cycle 0.
- Load/store to 32'h1001_0100 (Nloc=64, one past the end) and to 32'h1003_000C -> mem_readdata=0, no stall, RAM/LED unchanged, addr_err=1 until reset.
- Assert mem_rd and mem_wr together at 32'h1001_0004 with data 32'h5 -> no stall, mem_readdata=0. A subsequent load returns 32'h5.
- Pull reset low during RD_WAIT -> enable=1, led=0, addr_err=0 immediately. After release, reissue the load -> full 2-cycle response with correct data.
